ram_sync_ctrl: RTL

- Parametrised, clocked successor to the 512-byte combinational data RAM.
- Byte-addressed, little-endian storage with byte, halfword and word access and optional sign extension on reads.
- Adds a valid/ready request handshake, configurable wait states, registered responses, and fault detection for misaligned or out-of-range accesses.
- Sits between the CPU MEM stage (or a test loader) and data storage.

---
 rtl/ram_sync_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ram_sync_ctrl.sv
// Clocked byte-addressed data RAM with valid/ready request handshake,
// programmable wait states, registered responses and access fault detection.
module ram_sync_ctrl #(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              rw,
  input  logic              se,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              rsp_valid,
  output logic [31:0]       rdata,
  output logic              fault
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic              rw_q, rw_d;
  logic              se_q, se_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;

  logic [7:0]        mem_q [DEPTH];

  logic [2:0]        nbytes;
  logic [ADDR_W:0]   end_addr;
  logic              misalign;
  logic              out_of_range;
  logic              acc_fault;
  logic [AW-1:0]     a0, a1, a2, a3;
  logic [7:0]        b0, b1, b2, b3;
  logic [31:0]       rd_val;
  logic              commit;

  // Range check is done one bit wider than the address so addr+nbytes cannot wrap.
  always_comb begin
    unique case (size_q)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    misalign     = ((size_q == 2'b01) && addr_q[0]) ||
                   (size_q[1] && (addr_q[1:0] != 2'b00));
    end_addr     = {1'b0, addr_q} + (ADDR_W+1)'(nbytes);
    out_of_range = end_addr > (ADDR_W+1)'(DEPTH);
    acc_fault    = misalign | out_of_range;
  end

  always_comb begin
    a0 = addr_q[AW-1:0];
    a1 = a0 + AW'(1);
    a2 = a0 + AW'(2);
    a3 = a0 + AW'(3);
    b0 = mem_q[a0];
    b1 = mem_q[a1];
    b2 = mem_q[a2];
    b3 = mem_q[a3];
    unique case (size_q)
      2'b00:   rd_val = {{24{se_q & b0[7]}}, b0};
      2'b01:   rd_val = {{16{se_q & b1[7]}}, b1, b0};
      default: rd_val = {b3, b2, b1, b0};
    endcase
  end

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    se_d    = se_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          rw_d    = rw;
          se_d    = se;
          size_d  = size;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = 4'(WAIT_STATES);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          fault_d = acc_fault;
          rdata_d = (acc_fault || rw_q) ? '0 : rd_val;
          commit  = rw_q & ~acc_fault;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      se_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      se_q    <= se_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // Storage is never cleared; a reset at the commit edge still suppresses the write.
  always_ff @(posedge clk) begin
    if (commit && !reset) begin
      mem_q[a0] <= wdata_q[7:0];
      if (size_q != 2'b00) mem_q[a1] <= wdata_q[15:8];
      if (size_q[1]) begin
        mem_q[a2] <= wdata_q[23:16];
        mem_q[a3] <= wdata_q[31:24];
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rdata     = rdata_q;
  assign fault     = fault_q;

endmodule
